// File: rtl/ahb_cpuif_bridge.sv
// ahb_cpuif_bridge: AHB-Lite subordinate that converts each accepted transfer into a
// single-beat CSR cpuif request, with stall retry, ack/err completion and two-cycle ERROR.
module ahb_cpuif_bridge #(
   parameter int AhbAddrWidth = 32,
   parameter int CsrAddrWidth = 12,
   parameter int DataWidth    = 32
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    hsel_i,
   input  logic [AhbAddrWidth-1:0] haddr_i,
   input  logic [1:0]              htrans_i,
   input  logic                    hwrite_i,
   input  logic [2:0]              hsize_i,
   input  logic [DataWidth-1:0]    hwdata_i,
   input  logic                    hready_i,
   output logic                    hreadyout_o,
   output logic                    hresp_o,
   output logic [DataWidth-1:0]    hrdata_o,
   output logic                    cpuif_req_o,
   output logic                    cpuif_req_is_wr_o,
   output logic [CsrAddrWidth-1:0] cpuif_addr_o,
   output logic [DataWidth-1:0]    cpuif_wr_data_o,
   output logic [DataWidth-1:0]    cpuif_wr_biten_o,
   input  logic                    cpuif_req_stall_wr_i,
   input  logic                    cpuif_req_stall_rd_i,
   input  logic                    cpuif_rd_ack_i,
   input  logic                    cpuif_rd_err_i,
   input  logic                    cpuif_wr_ack_i,
   input  logic                    cpuif_wr_err_i,
   input  logic [DataWidth-1:0]    cpuif_rd_data_i
);
   typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DONE, S_ERR1, S_ERR2} state_t;
   state_t r_state, w_next;
   logic                    r_wr;
   logic [CsrAddrWidth-1:0] r_addr;
   logic [DataWidth-1:0]    r_biten, r_rdata, w_biten;
   logic w_open, w_new, w_hi, w_bad, w_stall, w_ack, w_err, w_cmpl, w_unused;

   assign w_unused = htrans_i[0];
   // A new address phase can only be taken while the previous data phase is completing.
   assign w_open = (r_state == S_IDLE) | (r_state == S_DONE) | (r_state == S_ERR2);
   assign w_new  = w_open & hsel_i & hready_i & htrans_i[1];
   generate
      if (AhbAddrWidth > CsrAddrWidth) begin : g_hi
         assign w_hi = |haddr_i[AhbAddrWidth-1:CsrAddrWidth];
      end else begin : g_nohi
         assign w_hi = 1'b0;
      end
   endgenerate
   assign w_bad = (hsize_i > 3'd2) | ((hsize_i == 3'd1) & haddr_i[0]) |
                  ((hsize_i == 3'd2) & (|haddr_i[1:0])) | w_hi;
   assign w_biten = !hwrite_i ? '0 :
                    (hsize_i == 3'd0) ? 32'h0000_00FF << {haddr_i[1:0], 3'b000} :
                    (hsize_i == 3'd1) ? 32'h0000_FFFF << {haddr_i[1], 4'b0000} : '1;

   // Only the strobes of the registered direction are honoured.
   assign w_stall = r_wr ? cpuif_req_stall_wr_i : cpuif_req_stall_rd_i;
   assign w_ack   = r_wr ? cpuif_wr_ack_i : cpuif_rd_ack_i;
   assign w_err   = r_wr ? cpuif_wr_err_i : cpuif_rd_err_i;
   assign w_cmpl  = (((r_state == S_REQ) & !w_stall) | (r_state == S_WAIT)) & w_ack;

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE, S_DONE, S_ERR2: w_next = w_new ? (w_bad ? S_ERR1 : S_REQ) : S_IDLE;
         S_REQ:   w_next = w_stall ? S_REQ : w_ack ? (w_err ? S_ERR1 : S_DONE) : S_WAIT;
         S_WAIT:  w_next = w_ack ? (w_err ? S_ERR1 : S_DONE) : S_WAIT;
         S_ERR1:  w_next = S_ERR2;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state <= S_IDLE;
         r_wr    <= 1'b0;
         r_addr  <= '0;
         r_biten <= '0;
         r_rdata <= '0;
      end else begin
         r_state <= w_next;
         if (w_new & !w_bad) begin
            r_wr    <= hwrite_i;
            r_addr  <= {haddr_i[CsrAddrWidth-1:2], 2'b00};
            r_biten <= w_biten;
         end
         if (w_cmpl | (w_new & w_bad))
            r_rdata <= (w_cmpl & !w_err & !r_wr) ? cpuif_rd_data_i : '0;
      end
   end

   assign hreadyout_o       = w_open;
   assign hresp_o           = (r_state == S_ERR1) | (r_state == S_ERR2);
   assign hrdata_o          = r_rdata;
   assign cpuif_req_o       = (r_state == S_REQ);
   assign cpuif_req_is_wr_o = r_wr;
   assign cpuif_addr_o      = r_addr;
   assign cpuif_wr_biten_o  = r_biten;
   assign cpuif_wr_data_o   = ((r_state == S_REQ) & r_wr) ? hwdata_i : '0;
endmodule
